hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard and stall/flush controller for the 5-stage core (pc/if/id/ex/mem/wb).
//  Keeps a load scoreboard of registers awaiting load data that EX/MEM forwarding cannot cover.
//  Arbitrates stall requests from ID (load-use), EX and MEM into one stall vector.
//  Sequences branch flushes, holding a flush request pending while a downstream stall is active.
// PARAMETERS
//  REG_NUM  32  architectural registers tracked (x0 never tracked)
//  REG_AW   5   register address width
//  STALL_W  6   stall vector width; bit0=pc, 1=if, 2=id, 3=ex, 4=mem, 5=wb
// PORTS
//  clk             in   1       core clock, rising edge
//  rst             in   1       asynchronous, active-high reset
//  id_valid_i      in   1       ID holds a real instruction this cycle
//  id_reg1_read_i  in   1       ID reads rs1
//  id_reg1_addr_i  in   REG_AW  rs1 address
//  id_reg2_read_i  in   1       ID reads rs2
//  id_reg2_addr_i  in   REG_AW  rs2 address
//  id_is_load_i    in   1       ID instruction is a load
//  id_wreg_i       in   1       ID instruction writes rd
//  id_wd_i         in   REG_AW  rd address
//  mem_ld_done_i   in   1       MEM returns load data this cycle (forwardable from here on)
//  mem_wd_i        in   REG_AW  rd of the completing load
//  stallreq_ex_i   in   1       EX multi-cycle stall request
//  stallreq_mem_i  in   1       MEM wait-state stall request
//  flush_req_i     in   1       EX resolved taken branch/jump; younger instructions squash
//  stall_o         out  STALL_W stall vector to pipeline registers
//  flush_o         out  1       one-cycle flush of the if/id and id/ex registers
//  busy_o          out  REG_NUM scoreboard snapshot; bit0 always 0
// BEHAVIOUR
//  Reset: busy=0, stall_o=0, flush_o=0, FSM=RUN, pending=0, perf counters=0. Reset is honoured mid-stall or mid-flush.
//  Load-use hazard (combinational):
//   hz = id_valid_i & ((reg1_read & busy[rs1]) | (reg2_read & busy[rs2])), with the current-cycle clear applied first.
//  Stall priority, combinational from requests and state:
//   stallreq_mem_i -> 6'b011111
//   else stallreq_ex_i -> 6'b001111
//   else hz -> 6'b000111; EX receives a bubble
//   else 6'b000000
//   Any active flush forces stall_o[2:0]=0.
//  Issue: iss = id_valid_i & ~stall_o[2] & ~flush_o.
//   On iss & id_is_load_i & id_wreg_i & id_wd_i!=0, set busy[id_wd_i] at the next edge.
//  Clear: mem_ld_done_i clears busy[mem_wd_i]. If the same register is set and cleared in one cycle, the set wins.
//  FSM, registered:
//   RUN: flush_req_i & ~stall_o[3] -> FLUSH. flush_req_i & stall_o[3] -> set pending, go to HOLD.
//   HOLD: when stall_o[3]=0 -> FLUSH, clear pending. A new flush_req_i while in HOLD is absorbed.
//   FLUSH: flush_o=1 for exactly one cycle, then -> RUN. A flush_req_i arriving in FLUSH is ignored (already squashed).
//  Latency: flush_o is asserted the cycle after an accepted request. stall_o has zero latency from its inputs.
//  Busy bits of older in-flight loads survive a flush. The squashed ID instruction never sets busy.
// CONFIGURATION
//  HAZARD_PERF_EN defined: add outputs perf_stall_cyc_o[31:0] and perf_flush_cnt_o[31:0].
//   perf_stall_cyc_o counts cycles with stall_o[0]=1; perf_flush_cnt_o counts flush_o pulses.
//   Both saturate at 32'hFFFF_FFFF and reset to 0.
//  HAZARD_PERF_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Shared defines: stall vector masks (StallNone, StallId, StallEx, StallMem) and FSM state codes (RUN/HOLD/FLUSH).
//   They sit alongside the existing RstEnable/WriteEnable defines.
//  One sub-module: load_scoreboard (busy register file with set/clear ports and the set-wins rule).
//   Stall arbitration and the FSM stay in hazard_ctrl.
// TESTING
//  Load x5, then add reading x5 next cycle -> stall_o=000111 until mem_ld_done_i(x5); issues the following cycle.
//  Load x0 -> busy_o stays 0, no stall. Load x7 with set and clear of x7 in the same cycle -> busy[7]=1.
//  stallreq_mem_i & stallreq_ex_i & hz together -> stall_o=011111; drop mem -> 001111.
//  flush_req_i with stallreq_ex_i high for 3 cycles -> HOLD; flush_o pulses one cycle after the stall drops; no set from the squashed ID instruction.
//  Assert rst during HOLD with busy[3]=1 -> all outputs 0 immediately; no flush after release.
//  With HAZARD_PERF_EN: 4 stall cycles and 2 flushes -> counters read 4 and 2.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared constants for the pipeline hazard controller: reset/write-enable
//   levels, register-file geometry, stall vector masks and FSM state codes.
//   Stall vector bit order: 0=pc, 1=if, 2=id, 3=ex, 4=mem, 5=wb.
//   Optional feature macro used by the top level: HAZARD_PERF_EN.
package hazard_ctrl_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic WriteEnable = 1'b1;

    localparam int REG_NUM = 32;
    localparam int REG_AW  = 5;
    localparam int STALL_W = 6;

    localparam logic [STALL_W-1:0] StallNone = 6'b000000;
    localparam logic [STALL_W-1:0] StallId   = 6'b000111;
    localparam logic [STALL_W-1:0] StallEx   = 6'b001111;
    localparam logic [STALL_W-1:0] StallMem  = 6'b011111;

    localparam logic [1:0] FSM_RUN   = 2'd0;
    localparam logic [1:0] FSM_HOLD  = 2'd1;
    localparam logic [1:0] FSM_FLUSH = 2'd2;

endpackage

// File: rtl/hazard_ctrl_load_scoreboard.sv
// load_scoreboard
//   One busy bit per architectural register, marking registers whose load
//   data has not yet reached the forwarding network.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     set_en/addr   mark a register busy at the next edge (x0 ignored)
//     clr_en/addr   load data returned; register is no longer busy
//     busy          registered scoreboard, bit0 always 0
//     busy_clr      busy with this cycle's clear already applied
//   A set and a clear of the same register in one cycle leaves it busy.
module load_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int SB_REG_NUM = REG_NUM,
    parameter int SB_REG_AW  = REG_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [SB_REG_AW-1:0]  set_addr,
    input  logic                  clr_en,
    input  logic [SB_REG_AW-1:0]  clr_addr,
    output logic [SB_REG_NUM-1:0] busy,
    output logic [SB_REG_NUM-1:0] busy_clr
);

    logic [SB_REG_NUM-1:0] clr_mask;
    logic [SB_REG_NUM-1:0] set_mask;
    logic [SB_REG_NUM-1:0] busy_nxt;

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (clr_en) begin
            clr_mask[clr_addr] = 1'b1;
        end
        if (set_en && (set_addr != '0)) begin
            set_mask[set_addr] = 1'b1;
        end
    end

    assign busy_clr = busy & ~clr_mask;

    // OR-ing the set after the clear gives the set priority.
    always_comb begin
        busy_nxt    = busy_clr | set_mask;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard and stall/flush controller for the 5-stage core.
//   Tracks outstanding loads in a scoreboard, merges load-use, EX and MEM
//   stall requests into one stall vector and sequences branch flushes,
//   deferring a flush while EX is stalled.
//   Ports:
//     clk, rst                    clock, asynchronous active-high reset
//     id_*                        instruction currently in ID
//     mem_ld_done_i, mem_wd_i     load data returning from MEM
//     stallreq_ex_i/mem_i         downstream stall requests
//     flush_req_i                 taken branch/jump resolved in EX
//     stall_o                     stall vector (0=pc .. 5=wb)
//     flush_o                     one-cycle flush of if/id and id/ex
//     busy_o                      scoreboard snapshot
//   Optional (HAZARD_PERF_EN): perf_stall_cyc_o, perf_flush_cnt_o,
//   saturating counters of stalled cycles and flush pulses.
//
//   state | meaning
//   RUN   | normal operation, accepts flush requests
//   HOLD  | flush requested while EX stalled; waiting for the stall to drop
//   FLUSH | flush_o asserted this cycle; new requests ignored
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int HC_REG_NUM = REG_NUM,
    parameter int HC_REG_AW  = REG_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid_i,
    input  logic                  id_reg1_read_i,
    input  logic [HC_REG_AW-1:0]  id_reg1_addr_i,
    input  logic                  id_reg2_read_i,
    input  logic [HC_REG_AW-1:0]  id_reg2_addr_i,
    input  logic                  id_is_load_i,
    input  logic                  id_wreg_i,
    input  logic [HC_REG_AW-1:0]  id_wd_i,
    input  logic                  mem_ld_done_i,
    input  logic [HC_REG_AW-1:0]  mem_wd_i,
    input  logic                  stallreq_ex_i,
    input  logic                  stallreq_mem_i,
    input  logic                  flush_req_i,
    output logic [STALL_W-1:0]    stall_o,
    output logic                  flush_o,
    output logic [HC_REG_NUM-1:0] busy_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           perf_stall_cyc_o,
    output logic [31:0]           perf_flush_cnt_o
`endif
);

    logic [HC_REG_NUM-1:0] busy_clr;
    logic                  hz;
    logic                  iss;
    logic                  set_en;
    logic [STALL_W-1:0]    stall_raw;
    logic [1:0]            state_q, state_d;
    logic                  pending_q, pending_d;

    load_scoreboard #(
        .SB_REG_NUM (HC_REG_NUM),
        .SB_REG_AW  (HC_REG_AW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en),
        .set_addr (id_wd_i),
        .clr_en   (mem_ld_done_i),
        .clr_addr (mem_wd_i),
        .busy     (busy_o),
        .busy_clr (busy_clr)
    );

    // Using the cleared view lets the dependent instruction leave ID in the
    // same cycle its load data becomes forwardable.
    assign hz = id_valid_i & ((id_reg1_read_i & busy_clr[id_reg1_addr_i]) |
                              (id_reg2_read_i & busy_clr[id_reg2_addr_i]));

    assign flush_o = (state_q == FSM_FLUSH);

    always_comb begin
        if (stallreq_mem_i) begin
            stall_raw = StallMem;
        end else if (stallreq_ex_i) begin
            stall_raw = StallEx;
        end else if (hz) begin
            stall_raw = StallId;
        end else begin
            stall_raw = StallNone;
        end
        // Front-end registers must load the redirected stream while flushing.
        if (flush_o) begin
            stall_raw[2:0] = 3'b000;
        end
    end

    // Stall is combinational, so gate it directly to keep it quiet in reset.
    assign stall_o = (rst == RstEnable) ? StallNone : stall_raw;

    assign iss    = id_valid_i & ~stall_o[2] & ~flush_o;
    assign set_en = iss & id_is_load_i & (id_wreg_i == WriteEnable);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            FSM_RUN: begin
                if (flush_req_i) begin
                    if (stall_o[3]) begin
                        state_d   = FSM_HOLD;
                        pending_d = 1'b1;
                    end else begin
                        state_d = FSM_FLUSH;
                    end
                end
            end
            FSM_HOLD: begin
                if (!pending_q) begin
                    state_d = FSM_RUN;
                end else if (!stall_o[3]) begin
                    state_d   = FSM_FLUSH;
                    pending_d = 1'b0;
                end
            end
            FSM_FLUSH: begin
                state_d = FSM_RUN;
            end
            default: begin
                state_d   = FSM_RUN;
                pending_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_q   <= FSM_RUN;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            perf_stall_cyc_o <= '0;
            perf_flush_cnt_o <= '0;
        end else begin
            if (stall_o[0] && (perf_stall_cyc_o != 32'hFFFF_FFFF)) begin
                perf_stall_cyc_o <= perf_stall_cyc_o + 32'd1;
            end
            if (flush_o && (perf_flush_cnt_o != 32'hFFFF_FFFF)) begin
                perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid_i = 1'b0;
    logic        id_reg1_read_i = 1'b0;
    logic [4:0]  id_reg1_addr_i = '0;
    logic        id_reg2_read_i = 1'b0;
    logic [4:0]  id_reg2_addr_i = '0;
    logic        id_is_load_i = 1'b0;
    logic        id_wreg_i = 1'b0;
    logic [4:0]  id_wd_i = '0;
    logic        mem_ld_done_i = 1'b0;
    logic [4:0]  mem_wd_i = '0;
    logic        stallreq_ex_i = 1'b0;
    logic        stallreq_mem_i = 1'b0;
    logic        flush_req_i = 1'b0;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] busy_o;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cyc_o;
    logic [31:0] perf_flush_cnt_o;
`endif

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid_i     (id_valid_i),
        .id_reg1_read_i (id_reg1_read_i),
        .id_reg1_addr_i (id_reg1_addr_i),
        .id_reg2_read_i (id_reg2_read_i),
        .id_reg2_addr_i (id_reg2_addr_i),
        .id_is_load_i   (id_is_load_i),
        .id_wreg_i      (id_wreg_i),
        .id_wd_i        (id_wd_i),
        .mem_ld_done_i  (mem_ld_done_i),
        .mem_wd_i       (mem_wd_i),
        .stallreq_ex_i  (stallreq_ex_i),
        .stallreq_mem_i (stallreq_mem_i),
        .flush_req_i    (flush_req_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .busy_o         (busy_o)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cyc_o (perf_stall_cyc_o),
        .perf_flush_cnt_o (perf_flush_cnt_o)
`endif
    );

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] busy;
        logic [31:0] pstall;
        logic [31:0] pflush;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: set of outstanding loads, a "flush owed" flag for a
    // deferred branch and a "flushing now" flag.
    bit [31:0] m_busy;
    bit        m_owed;
    bit        m_flush_now;
    bit [31:0] m_pstall;
    bit [31:0] m_pflush;

    task automatic cycle(input bit r, input bit v,
                         input bit r1, input bit [4:0] a1,
                         input bit r2, input bit [4:0] a2,
                         input bit ld, input bit wr, input bit [4:0] wd,
                         input bit dn, input bit [4:0] mwd,
                         input bit ex, input bit mm, input bit fl);
        exp_t      e;
        bit [31:0] ready_view;
        bit        hz, iss, ex_stalled;
        bit [5:0]  st;
        @(posedge clk);
        #1;
        rst = r; id_valid_i = v;
        id_reg1_read_i = r1; id_reg1_addr_i = a1;
        id_reg2_read_i = r2; id_reg2_addr_i = a2;
        id_is_load_i = ld; id_wreg_i = wr; id_wd_i = wd;
        mem_ld_done_i = dn; mem_wd_i = mwd;
        stallreq_ex_i = ex; stallreq_mem_i = mm; flush_req_i = fl;
        if (r) begin
            m_busy = '0; m_owed = 1'b0; m_flush_now = 1'b0;
            m_pstall = '0; m_pflush = '0;
            e = '{stall: 6'd0, flush: 1'b0, busy: 32'd0, pstall: 32'd0, pflush: 32'd0};
            q.push_back(e);
            return;
        end
        ready_view = m_busy;
        if (dn) ready_view[mwd] = 1'b0;
        hz = v && ((r1 && ready_view[a1]) || (r2 && ready_view[a2]));
        // Count of stalled stages from the oldest requester downward.
        if (mm)      st = 6'b011111;
        else if (ex) st = 6'b001111;
        else if (hz) st = 6'b000111;
        else         st = 6'b000000;
        if (m_flush_now) st[2:0] = 3'b000;
        e = '{stall: st, flush: m_flush_now, busy: m_busy, pstall: m_pstall, pflush: m_pflush};
        q.push_back(e);

        iss = v && !st[2] && !m_flush_now;
        m_busy = ready_view;
        if (iss && ld && wr && wd != 0) m_busy[wd] = 1'b1;

        ex_stalled = st[3];
        if (st[0] && m_pstall != 32'hFFFF_FFFF) m_pstall = m_pstall + 1;
        if (m_flush_now && m_pflush != 32'hFFFF_FFFF) m_pflush = m_pflush + 1;
        if (m_flush_now) begin
            m_flush_now = 1'b0;
        end else if (m_owed) begin
            if (!ex_stalled) begin
                m_owed = 1'b0;
                m_flush_now = 1'b1;
            end
        end else if (fl) begin
            if (ex_stalled) m_owed = 1'b1;
            else            m_flush_now = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Hand-derived expectations overriding the model for the latest cycle.
    task automatic pin_stall(input logic [5:0] s); q[$].stall = s; endtask
    task automatic pin_flush(input logic f);       q[$].flush = f; endtask
    task automatic pin_busy(input logic [31:0] b); q[$].busy = b;  endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (stall_o !== e.stall) begin
                    n_err++;
                    $display("FAIL stall_o: got %b want %b at %0t", stall_o, e.stall, $time);
                end
                n_vec++;
                if (flush_o !== e.flush) begin
                    n_err++;
                    $display("FAIL flush_o: got %b want %b at %0t", flush_o, e.flush, $time);
                end
                n_vec++;
                if (busy_o !== e.busy) begin
                    n_err++;
                    $display("FAIL busy_o: got %h want %h at %0t", busy_o, e.busy, $time);
                end
`ifdef HAZARD_PERF_EN
                n_vec++;
                if (perf_stall_cyc_o !== e.pstall) begin
                    n_err++;
                    $display("FAIL perf_stall: got %0d want %0d", perf_stall_cyc_o, e.pstall);
                end
                n_vec++;
                if (perf_flush_cnt_o !== e.pflush) begin
                    n_err++;
                    $display("FAIL perf_flush: got %0d want %0d", perf_flush_cnt_o, e.pflush);
                end
`endif
            end
        end
    end

    initial begin
        // reset
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        pin_stall(6'b0); pin_flush(1'b0); pin_busy(32'h0);
        cycle(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        pin_stall(6'b0); pin_flush(1'b0); pin_busy(32'h0);
        idle(1);

        // load x5, dependent add stalls until the load data returns
        cycle(0, 1, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0, 0);
        pin_stall(6'b000000);
        cycle(0, 1, 1, 5, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0);
        pin_stall(6'b000111); pin_busy(32'h0000_0020);
        cycle(0, 1, 1, 5, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0);
        pin_stall(6'b000111);
        cycle(0, 1, 0, 0, 1, 5, 0, 1, 6, 1, 5, 0, 0, 0);
        pin_stall(6'b000000); pin_busy(32'h0000_0020);
        idle(1);
        pin_busy(32'h0);

        // load x0 never becomes busy
        cycle(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        pin_stall(6'b0); pin_busy(32'h0);

        // set and clear of x7 in one cycle: set wins
        cycle(0, 1, 0, 0, 0, 0, 1, 1, 7, 1, 7, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        pin_busy(32'h0000_0080);

        // stall priority with a load-use hazard on x7 underneath
        cycle(0, 1, 1, 7, 0, 0, 0, 1, 8, 0, 0, 1, 1, 0);
        pin_stall(6'b011111);
        cycle(0, 1, 1, 7, 0, 0, 0, 1, 8, 0, 0, 1, 0, 0);
        pin_stall(6'b001111);
        cycle(0, 1, 1, 7, 0, 0, 0, 1, 8, 0, 0, 0, 0, 0);
        pin_stall(6'b000111);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        idle(1);
        pin_busy(32'h0);

        // flush deferred by an EX stall, then issued after the stall drops
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        pin_stall(6'b001111); pin_flush(1'b0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        pin_flush(1'b0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        pin_flush(1'b0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        pin_flush(1'b0); pin_stall(6'b0);
        cycle(0, 1, 0, 0, 0, 0, 1, 1, 9, 0, 0, 0, 0, 1);
        pin_flush(1'b1); pin_stall(6'b0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        pin_flush(1'b0); pin_busy(32'h0);

        // reset during HOLD with x3 busy
        cycle(0, 1, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        pin_busy(32'h0000_0008);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        pin_stall(6'b0); pin_flush(1'b0); pin_busy(32'h0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        pin_flush(1'b0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        pin_flush(1'b0); pin_busy(32'h0);

        // randomized traffic over a small register window to force hazards
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(99) == 0,
                  $urandom_range(9) < 7,
                  $urandom_range(1), 5'($urandom_range(7)),
                  $urandom_range(1), 5'($urandom_range(7)),
                  $urandom_range(9) < 3, $urandom_range(9) < 8, 5'($urandom_range(7)),
                  $urandom_range(3) == 0, 5'($urandom_range(7)),
                  $urandom_range(19) < 3, $urandom_range(19) < 2,
                  $urandom_range(9) == 0);
        end
        idle(2);

        @(posedge clk);
        #6;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
